memory_responder: RTL and testbench



---
 rtl/memory_responder_pkg.sv | 21 ++
 rtl/memory_responder_ram.sv | 24 ++
 rtl/memory_responder.sv | 150 +++++++++++++++
 tb/tb_memory_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared constants, helpers and FSM state type for the memory responder.
package configure;
  localparam logic [31:0] default_ram_base   = 32'h0000_0000;
  localparam logic [31:0] default_clint_base = 32'h0200_0000;
  localparam logic [15:0] clint_msip         = 16'h0000;
  localparam logic [15:0] clint_mtimecmp     = 16'h4000;
  localparam logic [15:0] clint_mtime        = 16'hBFF8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction
endpackage

package wires;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} responder_state_type;
endpackage

// File: rtl/memory_responder_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
module memory_ram #(
  parameter int DEPTH = 16384,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Read returns the word as it was before any same-edge write.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we && wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: RAM plus CLINT timer/soft-interrupt registers
// behind a valid/ready port with configurable response latency.
module memory_responder
  import configure::*, wires::*;
#(
  parameter logic [31:0] RAM_BASE   = default_ram_base,
  parameter int          RAM_DEPTH  = 16384,
  parameter logic [31:0] CLINT_BASE = default_clint_base,
  parameter int          LATENCY    = 1,
  parameter int          RTC_DIV    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_error,
  output logic        memory_ready,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int PW = $clog2(RTC_DIV + 1);

  responder_state_type state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, wd_q;
  logic [3:0]    s_q;
  logic          i_q;

  logic [31:0] acc_addr, acc_wdata, ram_q, rd_q, clint_rd;
  logic [3:0]  acc_wstrb;
  logic        acc_instr, commit, ram_hit, clint_hit, is_wr, cw, sel_ram_q;
  logic [32:0] off;
  logic [15:0] coff;
  logic [63:0] mtimecmp;
  logic [PW-1:0] presc;
  logic        tick;

  // With LATENCY=1 the commit edge is the accept edge, so use live inputs in IDLE.
  always_comb begin
    acc_addr  = (state == IDLE) ? memory_addr  : a_q;
    acc_wdata = (state == IDLE) ? memory_wdata : wd_q;
    acc_wstrb = (state == IDLE) ? memory_wstrb : s_q;
    acc_instr = (state == IDLE) ? memory_instr : i_q;
  end

  always_comb begin
    off       = {1'b0, acc_addr} - {1'b0, RAM_BASE};
    ram_hit   = ({1'b0, acc_addr} >= {1'b0, RAM_BASE}) &&
                ({1'b0, acc_addr} < ({1'b0, RAM_BASE} + (33'(RAM_DEPTH) << 2)));
    clint_hit = (acc_addr[31:16] == CLINT_BASE[31:16]) && !acc_instr;
    coff      = {acc_addr[15:2], 2'b00};
    is_wr     = |acc_wstrb;
    case (coff)
      clint_msip:            clint_rd = {31'b0, msip};
      clint_mtimecmp:        clint_rd = mtimecmp[31:0];
      clint_mtimecmp + 16'h4: clint_rd = mtimecmp[63:32];
      clint_mtime:           clint_rd = mtime[31:0];
      clint_mtime + 16'h4:   clint_rd = mtime[63:32];
      default:               clint_rd = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (memory_valid) begin
        cnt_n   = CW'(LATENCY - 1);
        state_n = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt_n == '0) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign commit       = (state_n == RESP) && (state != RESP);
  assign cw           = commit && clint_hit && is_wr;
  assign memory_ready = (state == RESP);
  assign memory_rdata = sel_ram_q ? ram_q : rd_q;
  assign tick         = (presc == PW'(RTC_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0; wd_q <= '0; s_q <= '0; i_q <= 1'b0;
      memory_error <= 1'b0;
      sel_ram_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && memory_valid) begin
        a_q <= memory_addr; wd_q <= memory_wdata; s_q <= memory_wstrb; i_q <= memory_instr;
      end
      if (commit) begin
        memory_error <= !(ram_hit || clint_hit);
        sel_ram_q    <= ram_hit && !is_wr;
        rd_q         <= clint_hit ? clint_rd : '0;
      end
    end
  end

  // A bus write to mtime replaces the increment for that cycle in both halves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      msip <= 1'b0;
      mtip <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      mtip  <= (mtime >= mtimecmp);
      if (cw && coff == clint_mtime)
        mtime <= {mtime[63:32], byte_merge(mtime[31:0], acc_wdata, acc_wstrb)};
      else if (cw && coff == clint_mtime + 16'h4)
        mtime <= {byte_merge(mtime[63:32], acc_wdata, acc_wstrb), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;
      if (cw && coff == clint_mtimecmp)
        mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], acc_wdata, acc_wstrb);
      if (cw && coff == clint_mtimecmp + 16'h4)
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], acc_wdata, acc_wstrb);
      if (cw && coff == clint_msip && acc_wstrb[0])
        msip <= acc_wdata[0];
    end
  end

  memory_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clock (clock),
    .en    (commit && ram_hit),
    .we    (is_wr),
    .addr  (AW'(off >> 2)),
    .wdata (acc_wdata),
    .wstrb (acc_wstrb),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_memory_responder.sv
// Directed + randomized check of memory_responder at LATENCY=1 and LATENCY=3.
module tb_memory_responder;
  localparam logic [31:0] CB = 32'h0200_0000;

  logic clock = 1'b0, reset = 1'b1;
  logic        valid [2], instr [2], err [2], ready [2], msip [2], mtip [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [3:0]  wstrb [2];
  logic [63:0] mtime [2];
  int lat [2] = '{1, 3};
  int tests = 0, fails = 0;
  longint unsigned cyc;

  logic [31:0] rd, dat, mdl [2][16];
  logic        er;
  bit          known [2][16];
  logic [3:0]  s;
  int          d, w, n;
  longint unsigned t0, tt;

  memory_responder #(.RAM_DEPTH(1024), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .memory_valid(valid[0]), .memory_instr(instr[0]),
    .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
    .memory_rdata(rdata[0]), .memory_error(err[0]), .memory_ready(ready[0]),
    .msip(msip[0]), .mtip(mtip[0]), .mtime(mtime[0]));

  memory_responder #(.RAM_DEPTH(1024), .LATENCY(3)) u3 (
    .clock(clock), .reset(reset), .memory_valid(valid[1]), .memory_instr(instr[1]),
    .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
    .memory_rdata(rdata[1]), .memory_error(err[1]), .memory_ready(ready[1]),
    .msip(msip[1]), .mtip(mtip[1]), .mtime(mtime[1]));

  always #5 clock = ~clock;

  // Reference timer: counts every non-reset edge (RTC_DIV=1).
  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0; else cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] v, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = v[8*b +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the ready pulse.
  task automatic req(input int di, input logic ins, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] ro, output logic eo);
    int k;
    bit got;
    valid[di] = 1'b1; instr[di] = ins; addr[di] = a; wdata[di] = wd; wstrb[di] = st;
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clock);
      k++;
      got = ready[di];
      if (!got && k == 1) begin
        addr[di] = $urandom; wdata[di] = $urandom; instr[di] = 1'b1;
      end
    end
    chk($sformatf("latency d%0d a=%h", di, a), 64'(k), 64'(lat[di]));
    ro = rdata[di]; eo = err[di];
    valid[di] = 1'b0;
    @(negedge clock);
    chk($sformatf("pulse d%0d", di), 64'(ready[di]), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      valid[i] = 0; instr[i] = 0; addr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst ready", 64'(ready[i]), 0); chk("rst err", 64'(err[i]), 0);
      chk("rst rdata", 64'(rdata[i]), 0); chk("rst msip", 64'(msip[i]), 0);
      chk("rst mtip", 64'(mtip[i]), 0);   chk("rst mtime", mtime[i], 0);
    end
    reset = 1'b0;
    @(negedge clock);

    req(0, 0, 32'h100, 32'hDEADBEEF, 4'hF, rd, er); chk("wr err", 64'(er), 0);
    req(0, 0, 32'h100, 32'h0, 4'h0, rd, er);
    chk("rd 100", 64'(rd), 64'hDEADBEEF); chk("rd err", 64'(er), 0);
    req(0, 0, 32'h200, 32'hFFFFFFFF, 4'hF, rd, er);
    req(0, 0, 32'h200, 32'h11223344, 4'h5, rd, er);
    req(0, 0, 32'h200, 32'h0, 4'h0, rd, er); chk("strobe", 64'(rd), 64'hFF22FF44);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1); w = $urandom_range(0, 15);
      if (!known[d][w] || $urandom_range(0, 1) == 1) begin
        s = known[d][w] ? 4'($urandom) : 4'hF;
        dat = $urandom;
        req(d, 0, 32'h400 + 32'(w * 4), dat, s, rd, er);
        mdl[d][w] = mrg(mdl[d][w], dat, s); known[d][w] = 1;
        chk("rnd wr err", 64'(er), 0);
      end else begin
        req(d, 0, 32'h400 + 32'(w * 4), 32'h0, 4'h0, rd, er);
        chk($sformatf("rnd rd d%0d w%0d", d, w), 64'(rd), 64'(mdl[d][w]));
      end
    end

    req(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er);
    chk("unmapped err", 64'(er), 1); chk("unmapped rdata", 64'(rd), 0);
    req(0, 1, CB, 32'h0, 4'h0, rd, er); chk("fetch clint err", 64'(er), 1);
    req(0, 0, 32'h0, 32'h0BADF00D, 4'hF, rd, er);
    req(0, 0, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er); chk("oob wr err", 64'(er), 1);
    req(0, 0, 32'h0, 32'h0, 4'h0, rd, er); chk("oob no alias", 64'(rd), 64'h0BADF00D);
    req(0, 0, 32'hFFC, 32'hCAFE0001, 4'hF, rd, er); chk("top word err", 64'(er), 0);
    req(0, 0, 32'hFFC, 32'h0, 4'h0, rd, er); chk("top word", 64'(rd), 64'hCAFE0001);

    req(0, 0, CB, 32'h1, 4'h1, rd, er); chk("msip out", 64'(msip[0]), 1);
    req(0, 0, CB, 32'h0, 4'h0, rd, er); chk("msip rd", 64'(rd), 1);
    req(0, 0, CB + 32'h100, 32'h0, 4'h0, rd, er);
    chk("hole rd", 64'(rd), 0); chk("hole err", 64'(er), 0);

    req(0, 0, CB + 32'h4004, 32'h0, 4'hF, rd, er);
    tt = cyc + 30;
    req(0, 0, CB + 32'h4000, tt[31:0], 4'hF, rd, er);
    chk("mtip low", 64'(mtip[0]), 0);
    n = 0;
    while (cyc != tt && n < 100) begin @(negedge clock); n++; end
    chk("mtime model", mtime[0], tt);
    chk("mtip lag", 64'(mtip[0]), 0);
    @(negedge clock); chk("mtip rise", 64'(mtip[0]), 1);
    req(0, 0, CB + 32'h4000, 32'h0, 4'h0, rd, er); chk("cmp lo rd", 64'(rd), 64'(tt[31:0]));
    t0 = cyc;
    req(0, 0, CB + 32'hBFF8, 32'h0, 4'h0, rd, er); chk("mtime lo rd", 64'(rd), 64'(t0[31:0]));
    req(0, 0, CB + 32'h4000, 32'hFFFFFFFF, 4'hF, rd, er); chk("mtip clear", 64'(mtip[0]), 0);
    req(0, 0, CB + 32'h4004, 32'h0000AB00, 4'h2, rd, er);
    req(0, 0, CB + 32'h4004, 32'h0, 4'h0, rd, er); chk("cmp hi strb", 64'(rd), 64'h0000AB00);

    valid[1] = 1; instr[1] = 0; addr[1] = CB; wstrb[1] = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk($sformatf("b2b cyc%0d", k), 64'(ready[1]), 64'((k % 4) == 3));
    end
    valid[1] = 0;
    @(negedge clock);

    req(1, 0, CB + 32'hBFF8, 32'h12345678, 4'hF, rd, er);
    chk("mtime wr", mtime[1], 64'h0000_0000_1234_5679);
    req(1, 0, CB + 32'hBFFC, 32'h000000AB, 4'h1, rd, er);
    req(1, 0, CB + 32'hBFFC, 32'h0, 4'h0, rd, er); chk("mtime hi wr", 64'(rd), 64'hAB);

    req(1, 0, 32'h300, 32'hAAAAAAAA, 4'hF, rd, er);
    valid[1] = 1; instr[1] = 0; addr[1] = 32'h300; wdata[1] = 32'h55555555; wstrb[1] = 4'hF;
    @(negedge clock);
    chk("pre-abort ready", 64'(ready[1]), 0);
    reset = 1'b1; valid[1] = 0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("abort ready", 64'(ready[i]), 0); chk("abort err", 64'(err[i]), 0);
      chk("abort rdata", 64'(rdata[i]), 0); chk("abort msip", 64'(msip[i]), 0);
      chk("abort mtip", 64'(mtip[i]), 0);   chk("abort mtime", mtime[i], 0);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    req(1, 0, 32'h300, 32'h0, 4'h0, rd, er); chk("abort no write", 64'(rd), 64'hAAAAAAAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
